coeff_pack12: RTL and testbench

- Consumer-side companion to barrett_reduce: takes its stream of reduced signed 16-bit coefficients and produces the Kyber 12-bit ByteEncode stream.
- Normalises each coefficient to canonical range [0, Q-1].
- Packs each coefficient pair into 3 bytes.
- Emits bytes over a valid/ready interface and marks the last byte of each polynomial.

---
 rtl/coeff_pack12.sv | 153 +++++++++++++++
 tb/tb_coeff_pack12.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_pack12.sv
// Normalises signed coefficients to [0, Q-1] and packs pairs into the 12-bit ByteEncode byte stream.
// Optional sticky input range flag: define COEFF_PACK12_RANGE_CHK_EN.
module coeff_pack12 #(
    parameter int unsigned Q = 3329,
    parameter int unsigned N = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] coeff_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
`ifdef COEFF_PACK12_RANGE_CHK_EN
    output logic        range_err,
`endif
    output logic        busy
);

    localparam int unsigned CW    = 12;
    localparam int unsigned PAIRS = N / 2;
    localparam int unsigned PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);
    localparam logic [CW-1:0] Q12 = CW'(Q);
    localparam logic signed [16:0] QS = 17'(Q);

    typedef enum logic [2:0] {S_C0, S_C1, S_B0, S_B1, S_B2} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   c0, c0_d, c1, c1_d, c;
    logic [PW-1:0]   cnt, cnt_d;
    logic            in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [7:0]      out_byte_d;
    logic signed [16:0] cx;
    logic            in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign cx       = {coeff_in[15], coeff_in};

    // Single-step normalisation; only the low 12 bits survive, so 12-bit arithmetic suffices.
    always_comb begin
        c = coeff_in[CW-1:0];
        if (cx[16]) begin
            c = coeff_in[CW-1:0] + Q12;
        end else if (cx >= QS) begin
            c = coeff_in[CW-1:0] - Q12;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_C0;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        c0_d       = c0;
        c1_d       = c1;
        cnt_d      = cnt;
        busy_d     = busy;
        out_byte_d = out_byte;
        out_last_d = out_last;
        case (state)
            S_C0: begin
                if (in_xfer) begin
                    c0_d    = c;
                    state_d = S_C1;
                    if (cnt == '0) begin
                        busy_d = 1'b1;
                    end
                end
            end
            S_C1: begin
                if (in_xfer) begin
                    c1_d       = c;
                    state_d    = S_B0;
                    out_byte_d = c0[7:0];
                end
            end
            S_B0: begin
                if (out_xfer) begin
                    state_d    = S_B1;
                    out_byte_d = {c1[3:0], c0[11:8]};
                end
            end
            S_B1: begin
                if (out_xfer) begin
                    state_d    = S_B2;
                    out_byte_d = c1[11:4];
                    out_last_d = (cnt == LAST_PAIR);
                end
            end
            S_B2: begin
                if (out_xfer) begin
                    state_d    = S_C0;
                    out_last_d = 1'b0;
                    if (out_last) begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                    end else begin
                        cnt_d  = cnt + PW'(1);
                    end
                end
            end
            default: state_d = S_C0;
        endcase
        in_ready_d  = (state_d == S_C0) || (state_d == S_C1);
        out_valid_d = (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0        <= '0;
            c1        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            c0        <= c0_d;
            c1        <= c1_d;
            cnt       <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_byte  <= out_byte_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
        end
    end

`ifdef COEFF_PACK12_RANGE_CHK_EN
    localparam logic signed [16:0] NQS = -17'(Q);
    localparam logic signed [16:0] Q2S = 17'(2 * Q);

    // Sticky flag for inputs outside the single-step normalisation domain [-Q, 2Q-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (in_xfer && ((cx < NQS) || (cx >= Q2S))) begin
            range_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_coeff_pack12.sv
// Self-checking bench for coeff_pack12: ByteEncode reference model, randomized backpressure and directed pins.
module tb_coeff_pack12;
    localparam int Q = 3329;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] coeff_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;
`ifdef COEFF_PACK12_RANGE_CHK_EN
    logic        range_err;
`endif

    coeff_pack12 #(.Q(Q), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .coeff_in(coeff_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last),
`ifdef COEFF_PACK12_RANGE_CHK_EN
        .range_err(range_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [11:0] pend[$];
    logic [7:0]  exp_b[$];
    logic        exp_l[$];
    logic [7:0]  got_b[$];
    logic        got_l[$];
    int          pairs_m = 0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic logic [11:0] norm(input int v);
        int r;
        r = v;
        if (r < 0) r = r + Q;
        else if (r >= Q) r = r - Q;
        return 12'(r);
    endfunction

    // ByteEncode_12: pair forms a little-endian 24-bit word c0 | c1<<12.
    task automatic model_push(input int v);
        logic [23:0] w;
        pend.push_back(norm(v));
        if (pend.size() == 2) begin
            w = {pend[1], pend[0]};
            pend.delete();
            for (int i = 0; i < 3; i++) begin
                exp_b.push_back(w[8*i +: 8]);
                exp_l.push_back((i == 2) && (pairs_m == N/2 - 1));
            end
            pairs_m = (pairs_m + 1) % (N/2);
        end
    endtask

    task automatic send(input int v, input int max_gap);
        int t;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        coeff_in = 16'(v);
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            model_push(v);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_b.size() != 0 || out_valid) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_b.size() != 0 || out_valid) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        pend.delete();
        exp_b.delete();
        exp_l.delete();
        pairs_m = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        chk({name, "_count"}, 32'(got_b.size()), 32'd3);
        if (got_b.size() >= 3) begin
            chk({name, "_b0"}, 32'(got_b[0]), 32'(b0));
            chk({name, "_b1"}, 32'(got_b[1]), 32'(b1));
            chk({name, "_b2"}, 32'(got_b[2]), 32'(b2));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output compare: every accepted byte against the model, plus hold-stable under backpressure.
    logic       pv = 1'b0;
    logic [7:0] pb = '0;
    logic       pl = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_byte", 32'(out_byte), 32'(pb));
                chk("hold_last", 32'(out_last), 32'(pl));
            end
            if (out_valid) chk("in_ready_low", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_b.size() == 0) begin
                    chk("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    chk("byte", 32'(out_byte), 32'(exp_b.pop_front()));
                    chk("last", 32'(out_last), 32'(exp_l.pop_front()));
                end
                got_b.push_back(out_byte);
                got_l.push_back(out_last);
            end
            pv = out_valid && !out_ready;
            pb = out_byte;
            pl = out_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int nlast;
        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Basic pair and first-byte latency
        got_b.delete(); got_l.delete();
        send(405, 0);
        send(3328, 0);
        @(negedge clk);
        #1;
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_byte", 32'(out_byte), 32'h95);
        chk("basic_busy", 32'(busy), 32'd1);
        drain();
        check_log("basic", 8'h95, 8'h01, 8'hD0);
        if (got_l.size() >= 3) chk("basic_last", 32'(got_l[2]), 32'd0);

        // Normalisation
        got_b.delete(); got_l.delete();
        send(-1, 0);
        send(3329, 0);
        drain();
        check_log("norm_a", 8'h00, 8'h0D, 8'h00);
        got_b.delete(); got_l.delete();
        send(405, 0);
        send(0, 0);
        drain();
        check_log("norm_b", 8'h95, 8'h01, 8'h00);

        // Backpressure held in S_B1
        got_b.delete(); got_l.delete();
        set_rdy(1'b0);
        send(405, 0);
        send(3328, 0);
        set_rdy(1'b1);
        set_rdy(1'b0);
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("bp_byte", 32'(out_byte), 32'h01);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        set_rdy(1'b1);
        drain();
        check_log("bp", 8'h95, 8'h01, 8'hD0);

        // Full polynomial of k, random backpressure
        do_reset();
        rand_rdy = 1'b1;
        got_b.delete(); got_l.delete();
        for (int k = 0; k < N; k++) begin
            send(k % Q, 1);
            if (k == 2) chk("poly_busy", 32'(busy), 32'd1);
        end
        drain();
        chk("poly_bytes", 32'(got_b.size()), 32'(3*N/2));
        nlast = 0;
        foreach (got_l[i]) if (got_l[i]) nlast++;
        chk("poly_nlast", 32'(nlast), 32'd1);
        if (got_l.size() == 3*N/2) chk("poly_last_pos", 32'(got_l[3*N/2-1]), 32'd1);
        chk("poly_busy_fall", 32'(busy), 32'd0);

        // Second polynomial, random in-contract values
        for (int k = 0; k < N; k++) begin
            send(int'($urandom_range(0, 3*Q-1)) - Q, 2);
        end
        drain();
        chk("poly2_bytes", 32'(got_b.size()), 32'(3*N));
        chk("poly2_busy_fall", 32'(busy), 32'd0);
        send(int'($urandom_range(0, Q-1)), 0);
        chk("poly3_busy_rise", 32'(busy), 32'd1);
        send(int'($urandom_range(0, Q-1)), 0);
        drain();
        rand_rdy = 1'b0;
        set_rdy(1'b1);

        // Reset mid-pair
        do_reset();
        send(100, 0);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        pend.delete(); exp_b.delete(); exp_l.delete(); pairs_m = 0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        got_b.delete(); got_l.delete();
        send(1, 0);
        send(2, 0);
        drain();
        check_log("mid", 8'h01, 8'h20, 8'h00);

`ifdef COEFF_PACK12_RANGE_CHK_EN
        do_reset();
        chk("rerr_rst", 32'(range_err), 32'd0);
        send(7000, 0);
        chk("rerr_set", 32'(range_err), 32'd1);
        send(0, 0);
        drain();
        chk("rerr_sticky", 32'(range_err), 32'd1);
        do_reset();
        send(-3329, 0);
        send(0, 0);
        drain();
        chk("rerr_edge", 32'(range_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
